// File: rtl/sd_bd_fifo_pkg.sv
// Shared constants for the SD buffer-descriptor store.
//   BD_DEPTH_DEF  : default number of descriptors held
//   RAM_MEM_WIDTH : descriptor word width
//   bd_word_e     : word index inside a descriptor (also the write/read phase)
package sd_bd_fifo_pkg;

  localparam int unsigned BD_DEPTH_DEF  = 8;
  localparam int unsigned RAM_MEM_WIDTH = 32;

  // Word 0 carries the system memory address, word 1 the card block address.
  typedef enum logic {
    BD_W_SYSADR  = 1'b0,
    BD_W_CARDADR = 1'b1
  } bd_word_e;

endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port synchronous RAM holding descriptor words.
//   wb_clk_i : clock
//   rst      : synchronous clear of the read data register
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata is registered and holds when re=0
module sd_bd_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = 1 << AW;

  logic [DW-1:0] mem [WORDS];

  // Write port
  always_ff @(posedge wb_clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge wb_clk_i) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_bd_fifo.sv
// Buffer-descriptor store: assembles 2-word descriptors from write strobes,
// keeps them in a circular buffer and returns them word by word.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   clr_i              : synchronous flush, same effect as reset
//   we_m_i, dat_in_m_i : descriptor word write strobe and data
//   re_s_i             : word read strobe; dat_out_s_o valid the next cycle
//   bd_avail_o         : at least one complete descriptor stored
//   free_bd_o          : free descriptor slots
//   wr_err_o, rd_err_o : one-cycle error pulses (dropped write, empty read)
module sd_bd_fifo
  import sd_bd_fifo_pkg::*;
#(
  parameter int unsigned BD_DEPTH = BD_DEPTH_DEF,
  parameter int unsigned DW       = RAM_MEM_WIDTH,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             clr_i,
  input  logic             we_m_i,
  input  logic [DW-1:0]    dat_in_m_i,
  input  logic             re_s_i,
  output logic [DW-1:0]    dat_out_s_o,
  output logic             bd_avail_o,
  output logic [CNT_W-1:0] free_bd_o,
  output logic             wr_err_o,
  output logic             rd_err_o
);

  localparam int unsigned SW = $clog2(BD_DEPTH);
  localparam int unsigned AW = SW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BD_DEPTH);

  logic [SW-1:0] wr_slot;
  logic [SW-1:0] rd_slot;
  bd_word_e      wr_phase;
  bd_word_e      rd_phase;
  logic          wr_drop;

  logic          flush;
  logic          wr_store;
  logic          commit;
  logic          rd_ok;
  logic          rd_take;
  logic          rd_release;

  assign flush = wb_rst_i | clr_i;

  // Accept/commit/release decisions for this cycle
  always_comb begin
    wr_store   = 1'b0;
    commit     = 1'b0;
    rd_ok      = 1'b0;
    rd_take    = 1'b0;
    rd_release = 1'b0;
    if (we_m_i) begin
      if (wr_phase == BD_W_SYSADR) wr_store = (free_bd_o != '0);
      else                         wr_store = !wr_drop;
    end
    commit = wr_store && (wr_phase == BD_W_CARDADR);
    // bd_avail_o lags the state by a cycle; also require that a committed
    // word really exists so a stale flag can never over-read.
    rd_ok      = (free_bd_o != FULL_CNT) || (rd_phase == BD_W_CARDADR);
    rd_take    = re_s_i && bd_avail_o && rd_ok;
    rd_release = rd_take && (rd_phase == BD_W_CARDADR);
  end

  // Pointers, phases, drop flag, free counter and error pulses
  always_ff @(posedge wb_clk_i) begin
    if (flush) begin
      wr_slot    <= '0;
      rd_slot    <= '0;
      wr_phase   <= BD_W_SYSADR;
      rd_phase   <= BD_W_SYSADR;
      wr_drop    <= 1'b0;
      free_bd_o  <= FULL_CNT;
      bd_avail_o <= 1'b0;
      wr_err_o   <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      wr_err_o <= 1'b0;
      rd_err_o <= 1'b0;

      // A dropped word 0 drags its word 1 along so pairing is preserved.
      if (we_m_i) begin
        if (wr_phase == BD_W_SYSADR) begin
          wr_phase <= BD_W_CARDADR;
          wr_drop  <= !wr_store;
          wr_err_o <= !wr_store;
        end else begin
          wr_phase <= BD_W_SYSADR;
          wr_drop  <= 1'b0;
          wr_err_o <= wr_drop;
          if (!wr_drop) wr_slot <= wr_slot + SW'(1);
        end
      end

      if (re_s_i) begin
        if (rd_take) begin
          if (rd_phase == BD_W_SYSADR) begin
            rd_phase <= BD_W_CARDADR;
          end else begin
            rd_phase <= BD_W_SYSADR;
            rd_slot  <= rd_slot + SW'(1);
          end
        end else begin
          rd_err_o <= 1'b1;
        end
      end

      case ({commit, rd_release})
        2'b10:   free_bd_o <= free_bd_o - CNT_W'(1);
        2'b01:   free_bd_o <= free_bd_o + CNT_W'(1);
        default: free_bd_o <= free_bd_o;
      endcase

      bd_avail_o <= (free_bd_o != FULL_CNT) || (rd_phase == BD_W_CARDADR);
    end
  end

  sd_bd_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .wb_clk_i (wb_clk_i),
    .rst      (flush),
    .we       (wr_store),
    .waddr    ({wr_slot, wr_phase}),
    .wdata    (dat_in_m_i),
    .re       (rd_take),
    .raddr    ({rd_slot, rd_phase}),
    .rdata    (dat_out_s_o)
  );

endmodule

// File: tb/tb_sd_bd_fifo.sv
// Directed self-checking bench for sd_bd_fifo (BD_DEPTH=8, DW=32).
module tb_sd_bd_fifo;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        we;
  logic [31:0] dat_in;
  logic        re;
  logic [31:0] dat_out;
  logic        bd_avail;
  logic [7:0]  free_bd;
  logic        wr_err;
  logic        rd_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sd_bd_fifo #(
    .BD_DEPTH (8),
    .DW       (32),
    .CNT_W    (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .clr_i       (clr),
    .we_m_i      (we),
    .dat_in_m_i  (dat_in),
    .re_s_i      (re),
    .dat_out_s_o (dat_out),
    .bd_avail_o  (bd_avail),
    .free_bd_o   (free_bd),
    .wr_err_o    (wr_err),
    .rd_err_o    (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write strobe; returns wr_err_o as seen right after the strobe edge.
  task automatic wr_word(input logic [31:0] d, output logic err);
    @(negedge clk);
    we = 1'b1; dat_in = d;
    @(negedge clk);
    we = 1'b0;
    err = wr_err;
  endtask

  task automatic rd_word(output logic [31:0] q, output logic err);
    @(negedge clk);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    q = dat_out; err = rd_err;
  endtask

  task automatic wr_rd(input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    we = 1'b1; dat_in = d; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    q = dat_out;
  endtask

  function automatic logic [31:0] sys_a(input int i);
    return 32'h2000_0000 + 32'(i) * 32'h100;
  endfunction

  logic [31:0] q;
  logic        e;
  logic [31:0] held;

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; dat_in = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state and first descriptor
    check("rst_free", 32'(free_bd), 32'd8);
    check("rst_avail", 32'(bd_avail), 32'd0);
    check("rst_dout", dat_out, 32'h0);
    wr_word(32'h1000_0000, e);
    check("s1_w0_err", 32'(e), 32'd0);
    check("s1_free_ph0", 32'(free_bd), 32'd8);
    wr_word(32'h0000_0040, e);
    check("s1_free", 32'(free_bd), 32'd7);
    check("s1_avail_lat", 32'(bd_avail), 32'd0);
    idle(1);
    check("s1_avail", 32'(bd_avail), 32'd1);

    // Read it back
    rd_word(q, e);
    check("s2_d0", q, 32'h1000_0000);
    check("s2_d0_err", 32'(e), 32'd0);
    rd_word(q, e);
    check("s2_d1", q, 32'h0000_0040);
    check("s2_free", 32'(free_bd), 32'd8);
    idle(1);
    check("s2_avail", 32'(bd_avail), 32'd0);

    // Fill (slots 1..7,0 -> wraps), overflow pair, drain in order
    for (int i = 0; i < 8; i++) begin
      wr_word(sys_a(i), e);
      wr_word(32'(i), e);
    end
    check("s3_full", 32'(free_bd), 32'd0);
    wr_word(32'hDEAD_0000, e);
    check("s3_ovf_err0", 32'(e), 32'd1);
    wr_word(32'hDEAD_0001, e);
    check("s3_ovf_err1", 32'(e), 32'd1);
    idle(1);
    check("s3_err_clr", 32'(wr_err), 32'd0);
    check("s3_full_hold", 32'(free_bd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_word(q, e);
      check($sformatf("s3_sys%0d", i), q, sys_a(i));
      rd_word(q, e);
      check($sformatf("s3_card%0d", i), q, 32'(i));
    end
    check("s3_free_end", 32'(free_bd), 32'd8);
    idle(1);
    check("s3_avail_end", 32'(bd_avail), 32'd0);

    // Simultaneous release + commit across the slot wrap
    for (int i = 0; i < 7; i++) begin
      wr_word(32'h4000_0000 + 32'(i), e);
      wr_word(32'h0000_1000 + 32'(i), e);
    end
    wr_word(32'h4000_0007, e);
    check("s4_free_pre", 32'(free_bd), 32'd1);
    rd_word(q, e);
    check("s4_rd0", q, 32'h4000_0000);
    wr_rd(32'h0000_1007, q);
    check("s4_rd1_sim", q, 32'h0000_1000);
    check("s4_free_sim", 32'(free_bd), 32'd1);
    for (int i = 1; i < 8; i++) begin
      rd_word(q, e);
      check($sformatf("s4_sys%0d", i), q, 32'h4000_0000 + 32'(i));
      rd_word(q, e);
      check($sformatf("s4_card%0d", i), q, 32'h0000_1000 + 32'(i));
    end
    check("s4_free_end", 32'(free_bd), 32'd8);
    idle(1);

    // Empty read
    held = dat_out;
    rd_word(q, e);
    check("s5_rd_err", 32'(e), 32'd1);
    check("s5_dout_hold", q, 32'h0000_1007);
    check("s5_dout_same", q, held);
    idle(1);
    check("s5_err_clr", 32'(rd_err), 32'd0);
    check("s5_free", 32'(free_bd), 32'd8);

    // Partial write discarded by reset
    wr_word(32'hAAAA_AAAA, e);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("s6_rst_free", 32'(free_bd), 32'd8);
    check("s6_rst_avail", 32'(bd_avail), 32'd0);
    check("s6_rst_dout", dat_out, 32'h0);
    wr_word(32'h3000_0000, e);
    wr_word(32'h0000_0077, e);
    check("s6_free", 32'(free_bd), 32'd7);
    idle(1);
    rd_word(q, e);
    check("s6_d0", q, 32'h3000_0000);
    rd_word(q, e);
    check("s6_d1", q, 32'h0000_0077);

    // Partial write and partial read discarded by clr
    wr_word(32'h5000_0000, e);
    wr_word(32'h0000_0055, e);
    idle(1);
    rd_word(q, e);
    check("s6c_rd0", q, 32'h5000_0000);
    wr_word(32'hBBBB_BBBB, e);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("s6c_free", 32'(free_bd), 32'd8);
    check("s6c_avail", 32'(bd_avail), 32'd0);
    check("s6c_dout", dat_out, 32'h0);
    wr_word(32'h6000_0000, e);
    wr_word(32'h0000_0066, e);
    idle(1);
    check("s6c_avail2", 32'(bd_avail), 32'd1);
    rd_word(q, e);
    check("s6c_d0", q, 32'h6000_0000);
    rd_word(q, e);
    check("s6c_d1", q, 32'h0000_0066);
    check("s6c_free2", 32'(free_bd), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
